// File: rtl/gmii_tx_mac.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS and inter-frame gap,
// in gigabit byte mode or 10/100 nibble mode (two cycles per byte slot).
module gmii_tx_mac #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_BYTES       = 12
) (
    input  logic       gmii_tx_clk,
    input  logic       reset,
    input  logic [1:0] speed_selection,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
    localparam logic [31:0] MIN_U    = 32'(MIN_FRAME_BYTES);
    localparam bit          NO_IFG   = (IFG_BYTES == 0);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_DISC
    } state_t;

    state_t      r_state, w_nxt_state;
    logic [15:0] r_cnt, w_nxt_cnt, r_bytes;
    logic [31:0] r_crc, w_crc_inv;
    logic [7:0]  r_byte, r_hold, w_nxt_byte, w_acc_byte, w_fcs_byte;
    logic        r_nib, r_half, r_got, r_got_last, r_last_acc;
    logic        w_slot_start, w_slot_end, w_acc, w_got, w_got_last, w_short;
    logic        w_nib_sel, w_nib_nxt;
    logic        w_nxt_en, w_nxt_er, w_count, w_start, w_done, w_urun;
    logic        w_gap_end, w_tail, w_to_ifg;
    logic [1:0]  w_fidx;

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // IDLE decides every cycle; elsewhere a nibble-mode slot ends on its second cycle.
    assign w_slot_start = !r_half;
    assign w_slot_end   = (r_state == S_IDLE) || !r_nib || r_half;

    assign s_ready = w_slot_start &&
                     ((r_state == S_SFD) || (r_state == S_DISC) ||
                      ((r_state == S_DATA) && !r_last_acc));

    assign w_acc      = s_valid && s_ready;
    assign w_got      = w_acc || r_got;
    assign w_got_last = (w_acc && s_last) || r_got_last;
    assign w_acc_byte = w_acc ? s_data : r_hold;
    assign w_short    = ({16'd0, r_bytes} < MIN_U);
    assign w_crc_inv  = ~r_crc;
    assign w_fidx     = r_cnt[1:0] + 2'd1;
    assign w_fcs_byte = w_crc_inv[{w_fidx, 3'b000} +: 8];
    assign w_nib_sel  = (speed_selection == 2'b01) || (speed_selection == 2'b00);
    assign w_nib_nxt  = w_start ? w_nib_sel : r_nib;

    // Next-slot decision; only applied by the register process at a slot end.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_byte  = 8'h00;
        w_nxt_en    = 1'b0;
        w_nxt_er    = 1'b0;
        w_count     = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_urun      = 1'b0;
        w_gap_end   = 1'b0;
        w_tail      = 1'b0;
        w_to_ifg    = 1'b0;
        case (r_state)
            S_IDLE: w_gap_end = 1'b1;
            S_PRE: begin
                w_nxt_en = 1'b1;
                if (r_cnt == 16'd6) begin
                    w_nxt_state = S_SFD;
                    w_nxt_cnt   = '0;
                    w_nxt_byte  = 8'hD5;
                end else begin
                    w_nxt_cnt  = r_cnt + 16'd1;
                    w_nxt_byte = 8'h55;
                end
            end
            S_SFD, S_DATA: begin
                w_nxt_en = 1'b1;
                if (w_got) begin
                    w_nxt_state = S_DATA;
                    w_nxt_byte  = w_acc_byte;
                    w_count     = 1'b1;
                end else if ((r_state == S_DATA) && r_last_acc) begin
                    w_tail = 1'b1;
                end else begin
                    // Source starved mid-frame: one error slot, then drain the rest.
                    w_nxt_state = S_DISC;
                    w_nxt_er    = 1'b1;
                    w_urun      = 1'b1;
                end
            end
            S_PAD: w_tail = 1'b1;
            S_FCS: begin
                if (r_cnt[1:0] == 2'd3) begin
                    w_done   = 1'b1;
                    w_to_ifg = 1'b1;
                end else begin
                    w_nxt_en   = 1'b1;
                    w_nxt_cnt  = r_cnt + 16'd1;
                    w_nxt_byte = w_fcs_byte;
                end
            end
            S_IFG: begin
                if (r_cnt == IFG_LAST) w_gap_end = 1'b1;
                else                   w_nxt_cnt = r_cnt + 16'd1;
            end
            S_DISC: w_to_ifg = w_got_last;
            default: w_nxt_state = S_IDLE;
        endcase

        if (w_tail) begin
            w_nxt_en = 1'b1;
            if (w_short) begin
                w_nxt_state = S_PAD;
                w_count     = 1'b1;
            end else begin
                w_nxt_state = S_FCS;
                w_nxt_cnt   = '0;
                w_nxt_byte  = w_crc_inv[7:0];
            end
        end

        if (w_to_ifg) begin
            if (NO_IFG) begin
                w_gap_end = 1'b1;
            end else begin
                w_nxt_state = S_IFG;
                w_nxt_cnt   = '0;
            end
        end

        if (w_gap_end) begin
            if (s_valid) begin
                w_nxt_state = S_PRE;
                w_nxt_cnt   = '0;
                w_nxt_byte  = 8'h55;
                w_nxt_en    = 1'b1;
                w_start     = 1'b1;
            end else begin
                w_nxt_state = S_IDLE;
            end
        end
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bytes    <= '0;
            r_crc      <= 32'hFFFF_FFFF;
            r_byte     <= '0;
            r_hold     <= '0;
            r_nib      <= 1'b0;
            r_half     <= 1'b0;
            r_got      <= 1'b0;
            r_got_last <= 1'b0;
            r_last_acc <= 1'b0;
            gmii_txd   <= '0;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (w_acc) r_hold <= s_data;
            r_half     <= !w_slot_end;
            frame_done <= w_slot_end && w_done;
            underrun   <= w_slot_end && w_urun;
            if (w_slot_end) begin
                r_got      <= 1'b0;
                r_got_last <= 1'b0;
                r_state    <= w_nxt_state;
                r_cnt      <= w_nxt_cnt;
                r_byte     <= w_nxt_byte;
                gmii_tx_en <= w_nxt_en;
                gmii_tx_er <= w_nxt_er;
                gmii_txd   <= w_nib_nxt ? {w_nxt_byte[3:0], w_nxt_byte[3:0]} : w_nxt_byte;
                if (w_got_last && ((r_state == S_SFD) || (r_state == S_DATA)))
                    r_last_acc <= 1'b1;
                if (w_count) begin
                    r_bytes <= (r_bytes == 16'hFFFF) ? r_bytes : r_bytes + 16'd1;
                    r_crc   <= crc_next(r_crc, w_nxt_byte);
                end
                if (w_start) begin
                    r_nib      <= w_nib_sel;
                    r_bytes    <= '0;
                    r_crc      <= 32'hFFFF_FFFF;
                    r_last_acc <= 1'b0;
                end
            end else begin
                if (w_acc) r_got <= 1'b1;
                if (w_acc && s_last) r_got_last <= 1'b1;
                gmii_txd <= {r_byte[7:4], r_byte[7:4]};
            end
        end
    end

endmodule
